// File: rtl/axis_pattern_gen.sv
// AXI-Stream pattern generator: byte-counter, constant and PRBS31 payloads.
// PRBS31 mode is built only when AXIS_PATTERN_GEN_PRBS_EN is defined.
module axis_pattern_gen #(
    parameter int DATA_WIDTH   = 64,
    parameter int LENGTH_WIDTH = 16,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    sys_arstn,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [1:0]              i_mode,
    input  logic [LENGTH_WIDTH-1:0] i_length,
    input  logic [COUNT_WIDTH-1:0]  i_pkt_count,
    input  logic [COUNT_WIDTH-1:0]  i_gap,
    input  logic [31:0]             i_seed,
    input  logic                    i_ready,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [DATA_WIDTH/8-1:0] o_keep,
    output logic                    o_valid,
    output logic                    o_last,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam logic [LENGTH_WIDTH:0] BM1 =
        (LENGTH_WIDTH + 1)'(BYTES - 1);
    localparam logic [LENGTH_WIDTH-1:0] LMASK =
        LENGTH_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t                  state;
    logic [1:0]              mode_q;
    logic [LENGTH_WIDTH-1:0] len_q;
    logic [COUNT_WIDTH-1:0]  cnt_q;
    logic [COUNT_WIDTH-1:0]  gap_q;
    logic [31:0]             seed_q;
    logic [LENGTH_WIDTH-1:0] beat;
    logic [COUNT_WIDTH-1:0]  sent;
    logic [COUNT_WIDTH-1:0]  gap_cnt;
    logic                    abort_q;
    logic [30:0]             prbs_init;
    logic [30:0]             prbs_cur;
    logic [30:0]             prbs_adv;

    function automatic logic [LENGTH_WIDTH-1:0] last_beat(
        input logic [LENGTH_WIDTH-1:0] len);
        logic [LENGTH_WIDTH:0] nb;
        nb = ({1'b0, len} + BM1) >> LB;
        return LENGTH_WIDTH'(nb - 1'b1);
    endfunction

    function automatic logic [BYTES-1:0] keep_of(
        input logic [LENGTH_WIDTH-1:0] len,
        input logic [LENGTH_WIDTH-1:0] n);
        logic [BYTES-1:0]        k;
        logic [LENGTH_WIDTH-1:0] rem;
        rem = len & LMASK;
        for (int i = 0; i < BYTES; i++)
            k[i] = (n != last_beat(len)) || (rem == '0) ||
                   (LENGTH_WIDTH'(i) < rem);
        return k;
    endfunction

    function automatic logic [1:0] eff_mode(input logic [1:0] m);
`ifdef AXIS_PATTERN_GEN_PRBS_EN
        return (m == 2'd3) ? 2'd0 : m;
`else
        return (m == 2'd1) ? 2'd1 : 2'd0;
`endif
    endfunction

    function automatic logic [DATA_WIDTH-1:0] gen_beat(
        input logic [1:0]              m,
        input logic [LENGTH_WIDTH-1:0] n,
        input logic [31:0]             s,
        input logic [30:0]             p);
        logic [DATA_WIDTH-1:0] d;
        logic [7:0]            base;
        logic [31:0]           pw;
        d    = '0;
        base = 8'(n << LB);
        pw   = {1'b0, p};
        if (m == 2'd1) begin
            for (int i = 0; i < DATA_WIDTH; i++) d[i] = s[i % 32];
        end else if (m == 2'd2) begin
            for (int i = 0; i < DATA_WIDTH; i++) d[i] = pw[i % 32];
        end else begin
            for (int k = 0; k < BYTES; k++)
                d[8*k +: 8] = base + 8'(k);
        end
        return d;
    endfunction

`ifdef AXIS_PATTERN_GEN_PRBS_EN
    logic [30:0] lfsr;

    assign prbs_init = (i_seed[30:0] == '0) ? 31'd1 : i_seed[30:0];
    assign prbs_cur  = lfsr;
    assign prbs_adv  = {lfsr[29:0], lfsr[30] ^ lfsr[27]};

    // State shown on the current beat; steps once per accepted beat.
    always_ff @(posedge clk or negedge sys_arstn) begin
        if (!sys_arstn)
            lfsr <= '0;
        else if (state == IDLE && i_start)
            lfsr <= prbs_init;
        else if (state == SEND && i_ready)
            lfsr <= prbs_adv;
    end
`else
    assign prbs_init = '0;
    assign prbs_cur  = '0;
    assign prbs_adv  = '0;
`endif

    always_ff @(posedge clk or negedge sys_arstn) begin
        if (!sys_arstn) begin
            state   <= IDLE;
            mode_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            seed_q  <= '0;
            beat    <= '0;
            sent    <= '0;
            gap_cnt <= '0;
            abort_q <= 1'b0;
            o_data  <= '0;
            o_keep  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (i_start) begin
                    mode_q  <= eff_mode(i_mode);
                    len_q   <= i_length;
                    cnt_q   <= i_pkt_count;
                    gap_q   <= i_gap;
                    seed_q  <= i_seed;
                    beat    <= '0;
                    sent    <= '0;
                    abort_q <= 1'b0;
                    if (i_length == '0) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else begin
                        state   <= SEND;
                        o_busy  <= 1'b1;
                        o_valid <= 1'b1;
                        o_data  <= gen_beat(eff_mode(i_mode), '0,
                                            i_seed, prbs_init);
                        o_keep  <= keep_of(i_length, '0);
                        o_last  <= (last_beat(i_length) == '0);
                    end
                end
                SEND: begin
                    if (i_abort) abort_q <= 1'b1;
                    if (i_ready) begin
                        if (beat == last_beat(len_q)) begin
                            sent <= sent + 1'b1;
                            beat <= '0;
                            if ((cnt_q != '0 && sent + 1'b1 == cnt_q) ||
                                abort_q || i_abort) begin
                                state   <= DONE;
                                o_valid <= 1'b0;
                                o_last  <= 1'b0;
                                o_data  <= '0;
                                o_keep  <= '0;
                                o_busy  <= 1'b0;
                                o_done  <= 1'b1;
                            end else if (gap_q != '0) begin
                                state   <= GAP;
                                gap_cnt <= gap_q - 1'b1;
                                o_valid <= 1'b0;
                                o_last  <= 1'b0;
                                o_data  <= '0;
                                o_keep  <= '0;
                            end else begin
                                o_data <= gen_beat(mode_q, '0,
                                                   seed_q, prbs_adv);
                                o_keep <= keep_of(len_q, '0);
                                o_last <= (last_beat(len_q) == '0);
                            end
                        end else begin
                            beat   <= beat + 1'b1;
                            o_data <= gen_beat(mode_q, beat + 1'b1,
                                               seed_q, prbs_adv);
                            o_keep <= keep_of(len_q, beat + 1'b1);
                            o_last <= (last_beat(len_q) == beat + 1'b1);
                        end
                    end
                end
                GAP: begin
                    if (i_abort) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else if (gap_cnt == '0) begin
                        state   <= SEND;
                        o_valid <= 1'b1;
                        o_data  <= gen_beat(mode_q, '0, seed_q, prbs_cur);
                        o_keep  <= keep_of(len_q, '0);
                        o_last  <= (last_beat(len_q) == '0);
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    o_done  <= 1'b0;
                    abort_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed bench for axis_pattern_gen (DATA_WIDTH=64).
module tb_axis_pattern_gen;

    logic        clk = 1'b0;
    logic        sys_arstn;
    logic        i_start;
    logic        i_abort;
    logic [1:0]  i_mode;
    logic [15:0] i_length;
    logic [7:0]  i_pkt_count;
    logic [7:0]  i_gap;
    logic [31:0] i_seed;
    logic        i_ready;
    logic [63:0] o_data;
    logic [7:0]  o_keep;
    logic        o_valid;
    logic        o_last;
    logic        o_busy;
    logic        o_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axis_pattern_gen #(
        .DATA_WIDTH(64), .LENGTH_WIDTH(16), .COUNT_WIDTH(8)
    ) dut (
        .clk(clk), .sys_arstn(sys_arstn),
        .i_start(i_start), .i_abort(i_abort),
        .i_mode(i_mode), .i_length(i_length),
        .i_pkt_count(i_pkt_count), .i_gap(i_gap),
        .i_seed(i_seed), .i_ready(i_ready),
        .o_data(o_data), .o_keep(o_keep),
        .o_valid(o_valid), .o_last(o_last),
        .o_busy(o_busy), .o_done(o_done)
    );

    typedef struct {
        string       nm;
        logic [1:0]  mode;
        int          len;
        int          cnt;
        int          gap;
        logic [31:0] seed;
        bit          rnd;
        int          ab_pkt;
        int          ab_beat;
        int          e_hs;
        int          e_pkts;
        logic [63:0] e_first;
        logic [7:0]  e_lkeep;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(
        input string nm, input logic [1:0] mode, input int len,
        input int cnt, input int gap, input logic [31:0] seed,
        input bit rnd, input int ab_pkt, input int ab_beat,
        input int e_hs, input int e_pkts,
        input logic [63:0] e_first, input logic [7:0] e_lkeep);
        vec_t v;
        v.nm = nm; v.mode = mode; v.len = len; v.cnt = cnt;
        v.gap = gap; v.seed = seed; v.rnd = rnd;
        v.ab_pkt = ab_pkt; v.ab_beat = ab_beat;
        v.e_hs = e_hs; v.e_pkts = e_pkts;
        v.e_first = e_first; v.e_lkeep = e_lkeep;
        return v;
    endfunction

    function automatic logic [63:0] model_data(
        input logic [1:0] m, input int n,
        input logic [31:0] s, input logic [30:0] p);
        logic [63:0] d;
        if (m == 2'd1) begin
            d = {s, s};
`ifdef AXIS_PATTERN_GEN_PRBS_EN
        end else if (m == 2'd2) begin
            d = {1'b0, p, 1'b0, p};
`endif
        end else begin
            for (int k = 0; k < 8; k++)
                d[8*k +: 8] = 8'((n * 8 + k) % 256);
        end
        return d;
    endfunction

    task automatic run(input vec_t v);
        int hs = 0, pkts = 0, n = 0, gcnt = 0, nb;
        int beat_err = 0, gap_err = 0, stall_err = 0, busy_err = 0;
        bit done = 0, in_gap = 0, pv = 0, pr = 0, pl = 0, rdy, lst;
        logic [63:0] first = '0, pd = '0;
        logic [7:0]  lkeep = '0, pk = '0, ek, lk;
        logic [30:0] p;
        nb = (v.len + 7) / 8;
        lk = (v.len % 8 == 0) ? 8'hFF : 8'((1 << (v.len % 8)) - 1);
        p  = (v.seed[30:0] == '0) ? 31'd1 : v.seed[30:0];
        @(negedge clk);
        i_mode = v.mode; i_length = 16'(v.len);
        i_pkt_count = 8'(v.cnt); i_gap = 8'(v.gap);
        i_seed = v.seed; i_start = 1'b1; i_ready = 1'b1; i_abort = 0;
        @(negedge clk);
        i_start = 1'b0;
        i_mode = ~v.mode; i_length = 16'(v.len + 5);
        i_pkt_count = 8'(v.cnt + 1); i_gap = 8'(v.gap + 3);
        i_seed = ~v.seed;
        chk(o_valid === 1'b1 && o_busy === 1'b1,
            {v.nm, " valid_after_start"},
            {62'd0, o_busy, o_valid}, 64'd3);
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_ready = rdy;
            i_abort = (v.ab_pkt != 0 && o_valid === 1'b1 &&
                       pkts + 1 == v.ab_pkt && n == v.ab_beat);
            if (pv && !pr && (o_valid !== 1'b1 || o_data !== pd ||
                              o_keep !== pk || o_last !== pl))
                stall_err++;
            if (o_done === 1'b1) begin
                done = 1;
                if (o_busy !== 1'b0 || o_valid !== 1'b0) busy_err++;
            end else begin
                if (in_gap) begin
                    if (o_valid === 1'b1) begin
                        if (gcnt != v.gap) gap_err++;
                        in_gap = 0;
                    end else gcnt++;
                end
                if (o_valid === 1'b1 && o_busy !== 1'b1) busy_err++;
                if (o_valid === 1'b1 && rdy) begin
                    lst = (n == nb - 1);
                    ek  = lst ? lk : 8'hFF;
                    if (hs == 0) first = o_data;
                    if (o_data !== model_data(v.mode, n, v.seed, p) ||
                        o_keep !== ek || o_last !== lst)
                        beat_err++;
                    hs++;
                    p = {p[29:0], p[30] ^ p[27]};
                    if (lst) begin
                        n = 0; pkts++; lkeep = o_keep;
                        in_gap = 1; gcnt = 0;
                    end else n++;
                end
            end
            pv = o_valid; pr = rdy; pd = o_data; pk = o_keep; pl = o_last;
            if (!done) @(negedge clk);
        end
        i_abort = 1'b0; i_ready = 1'b1;
        chk(done, {v.nm, " done_seen"}, 64'(done), 64'd1);
        chk(hs == v.e_hs, {v.nm, " handshakes"}, 64'(hs), 64'(v.e_hs));
        chk(pkts == v.e_pkts, {v.nm, " packets"},
            64'(pkts), 64'(v.e_pkts));
        chk(first === v.e_first, {v.nm, " first_data"}, first, v.e_first);
        chk(lkeep === v.e_lkeep, {v.nm, " last_keep"},
            64'(lkeep), 64'(v.e_lkeep));
        chk(beat_err == 0, {v.nm, " beat_content"}, 64'(beat_err), 0);
        chk(gap_err == 0, {v.nm, " gap_cycles"}, 64'(gap_err), 0);
        chk(stall_err == 0, {v.nm, " stall_hold"}, 64'(stall_err), 0);
        chk(busy_err == 0, {v.nm, " busy_flag"}, 64'(busy_err), 0);
        @(negedge clk);
        chk(o_done === 1'b0 && o_valid === 1'b0 && o_busy === 1'b0,
            {v.nm, " done_one_cycle"},
            {61'd0, o_done, o_valid, o_busy}, 0);
    endtask

    initial begin
        logic [63:0] prbs_first;
        int hs;
        bit dseen;
`ifdef AXIS_PATTERN_GEN_PRBS_EN
        prbs_first = 64'h0000_0001_0000_0001;
`else
        prbs_first = 64'h0706_0504_0302_0100;
`endif
        vecs[0] = mk("len640", 0, 640, 1, 0, 0, 0, 0, 0, 80, 1,
                     64'h0706050403020100, 8'hFF);
        vecs[1] = mk("len13_gap4", 0, 13, 3, 4, 0, 0, 0, 0, 6, 3,
                     64'h0706050403020100, 8'h1F);
        vecs[2] = mk("const_stall", 1, 64, 1, 0, 32'hA5A5A5A5, 1, 0, 0,
                     8, 1, 64'hA5A5A5A5A5A5A5A5, 8'hFF);
        vecs[3] = mk("mode3", 3, 9, 2, 1, 0, 0, 0, 0, 4, 2,
                     64'h0706050403020100, 8'h01);
        vecs[4] = mk("prbs", 2, 24, 2, 2, 1, 0, 0, 0, 6, 2,
                     prbs_first, 8'hFF);
        vecs[5] = mk("const7", 1, 7, 1, 0, 32'h12345678, 0, 0, 0, 1, 1,
                     64'h1234567812345678, 8'h7F);
        vecs[6] = mk("cnt16_rnd", 0, 16, 2, 0, 0, 1, 0, 0, 4, 2,
                     64'h0706050403020100, 8'hFF);
        vecs[7] = mk("abort_p5", 0, 64, 0, 2, 0, 0, 5, 3, 40, 5,
                     64'h0706050403020100, 8'hFF);
        vecs[8] = mk("len1", 0, 1, 1, 0, 0, 0, 0, 0, 1, 1,
                     64'h0706050403020100, 8'h01);

        sys_arstn = 1'b0; i_start = 0; i_abort = 0; i_mode = 0;
        i_length = 0; i_pkt_count = 0; i_gap = 0; i_seed = 0;
        i_ready = 1'b1;
        #12;
        chk(o_valid === 0 && o_last === 0 && o_busy === 0 &&
            o_done === 0, "reset_flags",
            {60'd0, o_valid, o_last, o_busy, o_done}, 0);
        chk(o_data === '0 && o_keep === '0, "reset_data",
            o_data | 64'(o_keep), 0);
        @(negedge clk);
        sys_arstn = 1'b1;

        foreach (vecs[i]) run(vecs[i]);

        // zero length: straight to DONE; a start held into DONE is ignored
        @(negedge clk);
        i_length = 0; i_pkt_count = 1; i_mode = 0; i_start = 1'b1;
        @(negedge clk);
        chk(o_done === 1'b1 && o_valid === 1'b0 && o_busy === 1'b0,
            "len0_done", {61'd0, o_done, o_valid, o_busy}, 64'd4);
        i_length = 16;
        @(negedge clk);
        i_start = 1'b0;
        chk(o_done === 0 && o_valid === 0 && o_busy === 0,
            "start_in_done", {61'd0, o_done, o_valid, o_busy}, 0);
        @(negedge clk);
        chk(o_valid === 1'b0, "start_in_done_valid", 64'(o_valid), 0);

        // abort while idling between packets
        i_length = 8; i_pkt_count = 0; i_gap = 5; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk(o_valid === 1'b1 && o_last === 1'b1, "gap_abort_beat",
            {62'd0, o_valid, o_last}, 64'd3);
        @(negedge clk);
        chk(o_valid === 1'b0, "gap_abort_in_gap", 64'(o_valid), 0);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk(o_done === 1'b1, "gap_abort_done", 64'(o_done), 64'd1);
        @(negedge clk);
        chk(o_done === 0 && o_busy === 0, "gap_abort_idle",
            {62'd0, o_done, o_busy}, 0);

        // reset on beat 10 of an 80-beat packet
        i_length = 640; i_pkt_count = 1; i_gap = 0; i_mode = 0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        hs = 0;
        for (int g = 0; g < 200 && hs < 10; g++) begin
            if (o_valid === 1'b1) hs++;
            @(negedge clk);
        end
        chk(o_data === 64'h5756555453525150, "beat10_data",
            o_data, 64'h5756555453525150);
        sys_arstn = 1'b0;
        #1;
        chk(o_valid === 0 && o_busy === 0 && o_data === '0,
            "mid_reset_clear", {62'd0, o_valid, o_busy}, 0);
        dseen = 0;
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            if (g == 2) sys_arstn = 1'b1;
            if (o_done === 1'b1 || o_valid === 1'b1) dseen = 1;
        end
        chk(!dseen, "mid_reset_no_done", 64'(dseen), 0);
        run(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
